mem_arbiter: RTL and testbench

//  Shares the single external memory port between the instruction fetcher
//  and the load/store unit (LSU). Grants one requester at a time, registers
//  the granted request onto the memory bus and routes the response back to
//  the owner. Sits between fetcher/LSU and the memory bus. Guards against

---
 rtl/mem_arbiter.sv | 113 +++++++++++
 tb/tb_mem_arbiter.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Arbitrates the single external memory port between instruction fetch and the LSU.
// Registers the granted request onto the bus and steers the response strobe back to its owner.
module mem_arbiter #(
  parameter int ARB_MODE     = 0,
  parameter int STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_mem_ready,
  input  logic [31:0] if_mem_addr,
  output logic        if_mem_valid,
  input  logic        lsu_mem_ready,
  input  logic [31:0] lsu_mem_addr,
  input  logic [31:0] lsu_mem_wdata,
  input  logic [3:0]  lsu_mem_wstrb,
  output logic        lsu_mem_valid,
  output logic [31:0] rdata,
  output logic        mem_ready,
  output logic        mem_instr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_valid,
  input  logic [31:0] mem_rdata,
  output logic        spurious_err
);

  localparam int CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {IDLE, BUSY, TURN} state_t;
  typedef enum logic {SIDE_IF, SIDE_LSU} side_t;

  state_t           state, state_next;
  side_t            owner, rr_last, winner;
  logic [CNT_W-1:0] starve_cnt;
  logic             req_if, req_lsu, grant, resp;

  // NOTE: every signal written here gets a default first, so no path leaves a latch.
  always_comb begin
    req_if     = if_mem_ready  && !(state == TURN && owner == SIDE_IF);
    req_lsu    = lsu_mem_ready && !(state == TURN && owner == SIDE_LSU);
    grant      = (state != BUSY) && (req_if || req_lsu);
    resp       = (state == BUSY) && mem_valid && !reset;
    winner     = SIDE_IF;
    state_next = state;

    if (req_if && req_lsu) begin
      if (ARB_MODE == 1)
        winner = (rr_last == SIDE_LSU) ? SIDE_IF : SIDE_LSU;
      else
        winner = (starve_cnt == CNT_MAX) ? SIDE_IF : SIDE_LSU;
    end else if (req_lsu) begin
      winner = SIDE_LSU;
    end

    case (state)
      IDLE:    state_next = grant ? BUSY : IDLE;
      BUSY:    state_next = mem_valid ? TURN : BUSY;
      TURN:    state_next = grant ? BUSY : IDLE;
      default: state_next = IDLE;
    endcase

    if_mem_valid  = resp && (owner == SIDE_IF);
    lsu_mem_valid = resp && (owner == SIDE_LSU);
    rdata         = mem_rdata;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      owner        <= SIDE_IF;
      rr_last      <= SIDE_LSU;
      starve_cnt   <= '0;
      mem_ready    <= 1'b0;
      mem_instr    <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      mem_wstrb    <= '0;
      spurious_err <= 1'b0;
    end else begin
      state <= state_next;

      if (grant) begin
        mem_ready <= 1'b1;
        owner     <= winner;
        rr_last   <= winner;
        if (winner == SIDE_IF) begin
          mem_instr  <= 1'b1;
          mem_addr   <= if_mem_addr;
          mem_wdata  <= '0;
          mem_wstrb  <= '0;
          starve_cnt <= '0;
        end else begin
          mem_instr <= 1'b0;
          mem_addr  <= lsu_mem_addr;
          mem_wdata <= lsu_mem_wdata;
          mem_wstrb <= lsu_mem_wstrb;
          if (if_mem_ready && starve_cnt != CNT_MAX)
            starve_cnt <= starve_cnt + 1'b1;
        end
      end else if (state == BUSY && mem_valid) begin
        mem_ready <= 1'b0;
      end

      // A response with no outstanding request is flagged until the next reset.
      if (mem_valid && state != BUSY)
        spurious_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized self-checking bench: two arbiters (fixed priority with guard, round-robin)
// are driven by independent requester/memory agents and compared each cycle to a transaction-level model.
module tb_mem_arbiter;

  localparam int N = 2;
  localparam int PH_FREE = 0, PH_SERVING = 1, PH_COOLDOWN = 2;
  localparam int SIDE_IF = 0, SIDE_LSU = 1;

  typedef struct {
    int          phase;
    int          owner;
    int          rr_last;
    int          starve;
    bit          ready;
    bit          instr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    bit          err;
  } model_t;

  logic clk = 1'b0;
  logic reset;
  logic [N-1:0]       if_rdy, lsu_rdy, mem_vld, if_vld, lsu_vld, mem_rdy, mem_ins, serr;
  logic [N-1:0][31:0] if_addr, lsu_addr, lsu_wdata, mem_rd, rdata_o, mem_addr_o, mem_wdata_o;
  logic [N-1:0][3:0]  lsu_wstrb, mem_wstrb_o;

  model_t m[N];
  model_t m_next[N];
  bit     prev_if_v[N];
  bit     prev_lsu_v[N];
  int     n_tests = 0;
  int     n_fail  = 0;
  int     grants_if[N];
  int     grants_lsu[N];

  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    mem_arbiter #(
      .ARB_MODE    (g),
      .STARVE_LIMIT(g == 0 ? 1 : 4)
    ) u_dut (
      .clk          (clk),
      .reset        (reset),
      .if_mem_ready (if_rdy[g]),
      .if_mem_addr  (if_addr[g]),
      .if_mem_valid (if_vld[g]),
      .lsu_mem_ready(lsu_rdy[g]),
      .lsu_mem_addr (lsu_addr[g]),
      .lsu_mem_wdata(lsu_wdata[g]),
      .lsu_mem_wstrb(lsu_wstrb[g]),
      .lsu_mem_valid(lsu_vld[g]),
      .rdata        (rdata_o[g]),
      .mem_ready    (mem_rdy[g]),
      .mem_instr    (mem_ins[g]),
      .mem_addr     (mem_addr_o[g]),
      .mem_wdata    (mem_wdata_o[g]),
      .mem_wstrb    (mem_wstrb_o[g]),
      .mem_valid    (mem_vld[g]),
      .mem_rdata    (mem_rd[g]),
      .spurious_err (serr[g])
    );
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic model_t reset_model();
    model_t r;
    r.phase = PH_FREE; r.owner = SIDE_IF; r.rr_last = SIDE_LSU; r.starve = 0;
    r.ready = 0; r.instr = 0; r.addr = '0; r.wdata = '0; r.wstrb = '0; r.err = 0;
    return r;
  endfunction

  // One clock of the arbitration rules, applied to a whole transaction view.
  function automatic model_t step(model_t c, int mode, int limit, bit rst, bit ir, bit lr,
                                  bit mv, logic [31:0] ia, logic [31:0] la,
                                  logic [31:0] lw, logic [3:0] ls);
    model_t n = c;
    bit     ci, cl;
    int     win;
    if (rst) return reset_model();
    if (c.phase == PH_SERVING) begin
      if (mv) begin
        n.phase = PH_COOLDOWN;
        n.ready = 0;
      end
      return n;
    end
    if (mv) n.err = 1;
    ci = ir && !(c.phase == PH_COOLDOWN && c.owner == SIDE_IF);
    cl = lr && !(c.phase == PH_COOLDOWN && c.owner == SIDE_LSU);
    if (!ci && !cl) begin
      n.phase = PH_FREE;
      return n;
    end
    if (ci && cl)
      win = (mode == 1) ? (c.rr_last == SIDE_LSU ? SIDE_IF : SIDE_LSU)
                        : (c.starve == limit ? SIDE_IF : SIDE_LSU);
    else
      win = cl ? SIDE_LSU : SIDE_IF;
    n.phase = PH_SERVING; n.ready = 1; n.owner = win; n.rr_last = win;
    if (win == SIDE_IF) begin
      n.instr = 1; n.addr = ia; n.wdata = '0; n.wstrb = '0; n.starve = 0;
    end else begin
      n.instr = 0; n.addr = la; n.wdata = lw; n.wstrb = ls;
      if (ir && c.starve < limit) n.starve = c.starve + 1;
    end
    return n;
  endfunction

  task automatic drive(input int i, input bit allow_spurious);
    if (if_rdy[i]) begin
      if (prev_if_v[i] && $urandom_range(0, 2) != 0) if_rdy[i] = 1'b0;
    end else if ($urandom_range(0, 3) == 0) begin
      if_rdy[i]  = 1'b1;
      if_addr[i] = $urandom() & 32'hFFFF_FFFC;
    end
    if (lsu_rdy[i]) begin
      if (prev_lsu_v[i] && $urandom_range(0, 2) != 0) lsu_rdy[i] = 1'b0;
    end else if ($urandom_range(0, 2) == 0) begin
      lsu_rdy[i]   = 1'b1;
      lsu_addr[i]  = $urandom();
      lsu_wdata[i] = $urandom();
      lsu_wstrb[i] = 4'($urandom_range(0, 15));
    end
    if (m[i].phase == PH_SERVING) mem_vld[i] = ($urandom_range(0, 2) == 0);
    else                          mem_vld[i] = allow_spurious && ($urandom_range(0, 9) == 0);
    mem_rd[i] = $urandom();
  endtask

  task automatic run_cycles(input int cycles, input int reset_mode, input bit allow_spurious);
    bit exp_if, exp_lsu;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (reset_mode == 2)      reset = 1'b1;
      else if (reset_mode == 1) reset = ($urandom_range(0, 24) == 0);
      else                      reset = 1'b0;
      for (int i = 0; i < N; i++) drive(i, allow_spurious);
      #1;
      for (int i = 0; i < N; i++) begin
        exp_if  = !reset && m[i].phase == PH_SERVING && mem_vld[i] && m[i].owner == SIDE_IF;
        exp_lsu = !reset && m[i].phase == PH_SERVING && mem_vld[i] && m[i].owner == SIDE_LSU;
        check($sformatf("u%0d if_valid", i),  32'(if_vld[i]),  32'(exp_if));
        check($sformatf("u%0d lsu_valid", i), 32'(lsu_vld[i]), 32'(exp_lsu));
        check($sformatf("u%0d rdata", i),     rdata_o[i],      mem_rd[i]);
        prev_if_v[i]  = if_vld[i];
        prev_lsu_v[i] = lsu_vld[i];
        m_next[i] = step(m[i], i, (i == 0) ? 1 : 4, reset, if_rdy[i], lsu_rdy[i], mem_vld[i],
                         if_addr[i], lsu_addr[i], lsu_wdata[i], lsu_wstrb[i]);
        if (m_next[i].phase == PH_SERVING && m[i].phase != PH_SERVING) begin
          if (m_next[i].owner == SIDE_IF) grants_if[i]++;
          else                            grants_lsu[i]++;
        end
      end
      @(posedge clk);
      #1;
      for (int i = 0; i < N; i++) begin
        m[i] = m_next[i];
        check($sformatf("u%0d mem_ready", i), 32'(mem_rdy[i]), 32'(m[i].ready));
        check($sformatf("u%0d mem_instr", i), 32'(mem_ins[i]), 32'(m[i].instr));
        check($sformatf("u%0d mem_addr", i),  mem_addr_o[i],   m[i].addr);
        check($sformatf("u%0d mem_wdata", i), mem_wdata_o[i],  m[i].wdata);
        check($sformatf("u%0d mem_wstrb", i), 32'(mem_wstrb_o[i]), 32'(m[i].wstrb));
        check($sformatf("u%0d spur_err", i),  32'(serr[i]),    32'(m[i].err));
      end
    end
  endtask

  initial begin
    reset = 1'b1;
    if_rdy = '0; lsu_rdy = '0; mem_vld = '0;
    if_addr = '0; lsu_addr = '0; lsu_wdata = '0; lsu_wstrb = '0; mem_rd = '0;
    for (int i = 0; i < N; i++) begin
      m[i] = reset_model();
      prev_if_v[i] = 0; prev_lsu_v[i] = 0;
      grants_if[i] = 0; grants_lsu[i] = 0;
    end
    run_cycles(3, 2, 1'b0);
    run_cycles(2000, 0, 1'b0);
    run_cycles(1500, 1, 1'b0);
    run_cycles(3, 2, 1'b0);
    run_cycles(800, 0, 1'b1);
    for (int i = 0; i < N; i++) begin
      check($sformatf("u%0d saw if grants", i),  32'(grants_if[i] > 10),  32'd1);
      check($sformatf("u%0d saw lsu grants", i), 32'(grants_lsu[i] > 10), 32'd1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
